mips_inst_encoder: RTL and testbench

- Inverse of the control decoder: turns a compact instruction request (mnemonic ID plus register, shamt, immediate and target fields) into a 32-bit MIPS instruction word.
- Writes the words sequentially into instruction memory through a stallable write port.
- Used by the on-board program loader and the self-test sequencer to build programs in IMEM without an external assembler.
- Single-entry output register; valid/ready on input, write/ready on memory side.

---
 rtl/mips_inst_encoder.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mips_inst_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_inst_encoder.sv
// -----------------------------------------------------------------------------
// mips_inst_encoder
//
// Builds 32-bit MIPS instruction words from compact requests (mnemonic ID plus
// register/shamt/immediate/target fields) and writes them one after another
// into instruction memory, starting at BASE_ADDR after each start pulse.
// Used by the program loader and the self-test sequencer to assemble programs
// directly into IMEM.
//
// Parameters
//   ADDR_W     IMEM word-address width
//   BASE_ADDR  first word address written after start
//   DEPTH      words writable before the encoder reports full
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              restart at BASE_ADDR, clear count and error, drop pending word
//   in_valid/in_ready  request handshake
//   in_mnem            mnemonic ID (0..41 legal, >= 42 illegal)
//   in_rs/in_rt/in_rd/in_shamt, in_imm, in_target   instruction fields
//   imem_we/imem_ready write handshake to IMEM (imem_we = output register valid)
//   imem_addr          word address of the presented word
//   imem_wdata         presented instruction word
//   word_count         words written since start
//   done               all DEPTH words written
//   err_illegal        sticky illegal-mnemonic flag
//
// Build option
//   ENC_DELAY_SLOT_NOP_EN  when defined, a NOP word follows every jump/branch.
// -----------------------------------------------------------------------------
module mips_inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err_illegal
);

  localparam int                DATA_W = 32;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE_ADDR + DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                vld_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic                err_q;
  logic                acc;
  logic                wr_done;
  logic                legal_p0;
  logic [DATA_W-1:0]   enc_p0;
  logic                gate_ok;

  // R-type function codes
  function automatic logic [5:0] r_funct(input logic [5:0] mnem);
    logic [5:0] f;
    f = 6'd0;
    case (mnem)
      6'd0:    f = 6'd0;
      6'd1:    f = 6'd2;
      6'd2:    f = 6'd3;
      6'd3:    f = 6'd4;
      6'd4:    f = 6'd6;
      6'd5:    f = 6'd7;
      6'd6:    f = 6'd8;
      6'd7:    f = 6'd12;
      6'd8:    f = 6'd32;
      6'd9:    f = 6'd33;
      6'd10:   f = 6'd34;
      6'd11:   f = 6'd35;
      6'd12:   f = 6'd36;
      6'd13:   f = 6'd37;
      6'd14:   f = 6'd38;
      6'd15:   f = 6'd39;
      6'd16:   f = 6'd42;
      6'd17:   f = 6'd43;
      default: f = 6'd0;
    endcase
    return f;
  endfunction

  // Primary opcodes for everything that is not R-type
  function automatic logic [5:0] i_opcode(input logic [5:0] mnem);
    logic [5:0] op;
    op = 6'd0;
    case (mnem)
      6'd18:        op = 6'd2;
      6'd19:        op = 6'd3;
      6'd20:        op = 6'd4;
      6'd21:        op = 6'd5;
      6'd22:        op = 6'd6;
      6'd23:        op = 6'd7;
      6'd24:        op = 6'd8;
      6'd25:        op = 6'd9;
      6'd26:        op = 6'd10;
      6'd27:        op = 6'd11;
      6'd28:        op = 6'd12;
      6'd29:        op = 6'd13;
      6'd30:        op = 6'd14;
      6'd31:        op = 6'd15;
      6'd32:        op = 6'd32;
      6'd33:        op = 6'd33;
      6'd34:        op = 6'd35;
      6'd35:        op = 6'd36;
      6'd36:        op = 6'd37;
      6'd37:        op = 6'd40;
      6'd38:        op = 6'd41;
      6'd39:        op = 6'd43;
      6'd40, 6'd41: op = 6'd1;
      default:      op = 6'd0;
    endcase
    return op;
  endfunction

  // Full instruction assembly; fields an instruction does not use are zeroed
  function automatic logic [31:0] encode_word(
    input logic [5:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    logic [5:0]  op;
    logic [5:0]  fn;
    op = i_opcode(mnem);
    fn = r_funct(mnem);
    w  = '0;
    case (mnem)
      6'd0, 6'd1, 6'd2:                     w = {6'd0, 5'd0, rt, rd, shamt, fn};
      6'd3, 6'd4, 6'd5:                     w = {6'd0, rs, rt, rd, 5'd0, fn};
      6'd6:                                 w = {6'd0, rs, 15'd0, fn};
      6'd7:                                 w = {26'd0, fn};
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
      6'd13, 6'd14, 6'd15, 6'd16, 6'd17:    w = {6'd0, rs, rt, rd, 5'd0, fn};
      6'd18, 6'd19:                         w = {op, target};
      6'd22, 6'd23:                         w = {op, rs, 5'd0, imm};
      6'd31:                                w = {op, 5'd0, rt, imm};
      6'd20, 6'd21, 6'd24, 6'd25, 6'd26,
      6'd27, 6'd28, 6'd29, 6'd30, 6'd32,
      6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
      6'd38, 6'd39:                         w = {op, rs, rt, imm};
      6'd40:                                w = {op, rs, 5'd0, imm};
      6'd41:                                w = {op, rs, 5'd1, imm};
      default:                              w = '0;
    endcase
    return w;
  endfunction

`ifdef ENC_DELAY_SLOT_NOP_EN
  function automatic logic has_delay_slot(input logic [5:0] mnem);
    logic b;
    b = 1'b0;
    case (mnem)
      6'd6, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd40, 6'd41: b = 1'b1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  logic nop_pend_q;   // output register holds a jump/branch whose NOP is still owed
  logic nop_out_q;    // output register holds the inserted NOP
  logic branch_p0;
  assign branch_p0 = has_delay_slot(in_mnem);
  assign gate_ok   = !nop_pend_q && !nop_out_q;
`else
  assign gate_ok   = 1'b1;
`endif

  // ---- Stage p0: request decode (combinational) ----
  assign legal_p0 = (in_mnem < 6'd42);
  assign enc_p0   = encode_word(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  assign wr_done  = vld_p1 && imem_ready;
  assign acc      = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        // A word already queued for the last address blocks further intake,
        // so nothing can be accepted that would have no slot to land in.
        in_ready = !start && gate_ok &&
                   (!vld_p1 || (imem_ready && (addr_q != LAST_A)));
        if (start)                                state_d = RUN;
        else if (wr_done && (addr_q == LAST_A))   state_d = FULL;
      end
      FULL: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- Stage p1: output register and write bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      wdata_p1   <= '0;
      addr_q     <= BASE_A;
      count_q    <= '0;
      err_q      <= 1'b0;
`ifdef ENC_DELAY_SLOT_NOP_EN
      nop_pend_q <= 1'b0;
      nop_out_q  <= 1'b0;
`endif
    end else if (start) begin
      vld_p1     <= 1'b0;
      addr_q     <= BASE_A;
      count_q    <= '0;
      err_q      <= 1'b0;
`ifdef ENC_DELAY_SLOT_NOP_EN
      nop_pend_q <= 1'b0;
      nop_out_q  <= 1'b0;
`endif
    end else begin
      if (wr_done) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (acc) begin
        if (legal_p0) begin
          vld_p1     <= 1'b1;
          wdata_p1   <= enc_p0;
`ifdef ENC_DELAY_SLOT_NOP_EN
          nop_pend_q <= branch_p0;
          nop_out_q  <= 1'b0;
`endif
        end else begin
          vld_p1 <= 1'b0;
          err_q  <= 1'b1;
        end
      end else if (wr_done) begin
`ifdef ENC_DELAY_SLOT_NOP_EN
        // A branch that lands on the last address loses its NOP.
        if (nop_pend_q && (addr_q != LAST_A)) begin
          vld_p1     <= 1'b1;
          wdata_p1   <= '0;
          nop_pend_q <= 1'b0;
          nop_out_q  <= 1'b1;
        end else begin
          vld_p1     <= 1'b0;
          nop_pend_q <= 1'b0;
          nop_out_q  <= 1'b0;
        end
`else
        vld_p1 <= 1'b0;
`endif
      end
    end
  end

  assign imem_we     = vld_p1;
  assign imem_wdata  = wdata_p1;
  assign imem_addr   = addr_q;
  assign word_count  = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_inst_encoder
//
// Directed bench for mips_inst_encoder (DEPTH=4). Stimulus pushes expected
// {address, word} pairs into a queue; a monitor pops one per completed IMEM
// write and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we;
  logic        imem_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_count;
  logic        done;
  logic        err_illegal;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [41:0] exp_q[$];
  int          wr_cycles[$];
  logic [9:0]  exp_addr;

  mips_inst_encoder #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .done(done),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      logic [41:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL imem_write: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                   imem_addr, imem_wdata, e[41:32], e[31:0]);
        end
      end
      wr_cycles.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tgt);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt;
  endtask

  // Issue one request; expected word (if any) goes to the scoreboard first.
  task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt,
                      input logic exp_wr, input logic [31:0] exp_w);
    bit ok;
    ok = 1'b0;
    set_req(m, rs, rt, rd, sh, imm, tgt);
    in_valid = 1'b1;
    if (exp_wr) begin
      exp_q.push_back({exp_addr, exp_w});
      exp_addr = exp_addr + 10'd1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake_timeout: got no acceptance of mnem %0d, expected acceptance within 50 cycles", m);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    check("start_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    exp_addr = '0;
    set_req(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_imem_we",   32'(imem_we),     32'd0);
    check("rst_imem_addr", 32'(imem_addr),   32'd0);
    check("rst_wdata",     imem_wdata,       32'd0);
    check("rst_count",     32'(word_count),  32'd0);
    check("rst_done",      32'(done),        32'd0);
    check("rst_err",       32'(err_illegal), 32'd0);
    check("rst_in_ready",  32'(in_ready),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;

    // Basic encoding
    pulse_start();
    send(6'd8,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00221820);
    send(6'd24, 5'd0,  5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b1, 32'h20080005);
    send(6'd34, 5'd29, 5'd2, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 32'h8FA20004);
    send(6'd0,  5'd7,  5'd3, 5'd2, 5'd4, 16'h0000, 26'd0, 1'b1, 32'h00031100);
    repeat (3) @(negedge clk);
    check("enc_word_count", 32'(word_count), 32'd4);
    check("enc_done",       32'(done),       32'd1);
    check("enc_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // REGIMM / jump / SYSCALL back to back
    pulse_start();
    wr_cycles.delete();
    send(6'd41, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'd0,       1'b1, 32'h0481FFFE);
    send(6'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0100000, 1'b1, 32'h08100000);
    send(6'd7,  5'd5, 5'd6, 5'd7, 5'd9, 16'h1234, 26'h3FFFFFF,  1'b1, 32'h0000000C);
    repeat (3) @(negedge clk);
    check("b2b_write_count", 32'(wr_cycles.size()), 32'd3);
    if (wr_cycles.size() == 3)
      check("b2b_consecutive", 32'(wr_cycles[2] - wr_cycles[0]), 32'd2);
    @(posedge clk); #1;

    // Stall
    pulse_start();
    imem_ready = 1'b0;
    send(6'd13, 5'd6, 5'd7, 5'd5, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00C72825);
    set_req(6'd10, 5'd2, 5'd3, 5'd1, 5'd0, 16'h0000, 26'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready),   32'd0);
      check("stall_we",       32'(imem_we),    32'd1);
      check("stall_wdata",    imem_wdata,      32'h00C72825);
      check("stall_addr",     32'(imem_addr),  32'd0);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    send(6'd10, 5'd2, 5'd3, 5'd1, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00430822);
    send(6'd29, 5'd5, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b1, 32'h34A41234);
    repeat (3) @(negedge clk);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    check("stall_count",       32'(word_count),   32'd3);
    @(posedge clk); #1;

    // Full
    pulse_start();
    send(6'd25, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b1, 32'h24010001);
    send(6'd25, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0002, 26'd0, 1'b1, 32'h24020002);
    send(6'd25, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0003, 26'd0, 1'b1, 32'h24030003);
    send(6'd25, 5'd0, 5'd4, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 32'h24040004);
    set_req(6'd25, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0005, 26'd0);
    in_valid = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    check("full_5th_rejected", 32'(seen),       32'd0);
    check("full_done",         32'(done),       32'd1);
    check("full_in_ready",     32'(in_ready),   32'd0);
    check("full_count",        32'(word_count), 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_start();
    @(negedge clk);
    check("restart_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    send(6'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00221820);
    repeat (2) @(negedge clk);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Illegal mnemonic, then start colliding with a request
    pulse_start();
    send(6'd45, 5'd1, 5'd2, 5'd3, 5'd4, 16'hABCD, 26'd0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    check("illegal_err",   32'(err_illegal), 32'd1);
    check("illegal_count", 32'(word_count),  32'd0);
    check("illegal_no_we", 32'(imem_we),     32'd0);
    @(posedge clk); #1;
    set_req(6'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0);
    in_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("collide_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    exp_addr = '0;
    @(negedge clk);
    check("collide_err_cleared", 32'(err_illegal), 32'd0);
    check("collide_count",       32'(word_count),  32'd0);
    repeat (2) @(negedge clk);
    check("collide_no_write", 32'(exp_q.size()), 32'd0);
    check("collide_we",       32'(imem_we),      32'd0);
    @(posedge clk); #1;

    // Branch, optionally followed by an inserted NOP
    pulse_start();
    send(6'd20, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'd0, 1'b1, 32'h10220003);
`ifdef ENC_DELAY_SLOT_NOP_EN
    exp_q.push_back({exp_addr, 32'h00000000});
    exp_addr = exp_addr + 10'd1;
    @(negedge clk);
    check("branch_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("nop_we",       32'(imem_we),  32'd1);
    check("nop_wdata",    imem_wdata,    32'h00000000);
    check("nop_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
`endif
    send(6'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00221820);
    repeat (3) @(negedge clk);
    check("branch_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a stalled write
    pulse_start();
    imem_ready = 1'b0;
    send(6'd14, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00210826);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we",    32'(imem_we),    32'd0);
    check("async_rst_wdata", imem_wdata,      32'd0);
    check("async_rst_count", 32'(word_count), 32'd0);
    void'(exp_q.pop_back());
    exp_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready),     32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
